i2c_byte_master: RTL and testbench

I2C_BYTE_MASTER -- requirements
Module: i2c_byte_master

---
 rtl/i2c_byte_master.sv | 185 ++++++++++++++++++
 tb/tb_i2c_byte_master.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_byte_master.sv
// Single-byte I2C master: START/STOP, byte write with ACK sense, byte read with
// master ACK, and SCL clock-stretch wait with timeout abort. Open-drain bus pins.
module i2c_byte_master #(
  parameter int unsigned CLK_DIV     = 125,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       go,
  input  logic       start,
  input  logic       stop,
  input  logic       rw,
  input  logic [7:0] data_w,
  output logic       ack,
  output logic       nack,
  output logic       ack_r,
  output logic       timeout,
  output logic [7:0] data_r,
  output logic       busy,
  output logic [2:0] state,
  output logic       SDA_t,
  output logic       SCL_t,
  output logic       SDA_o,
  output logic       SCL_o,
  input  logic       SDA_i,
  input  logic       SCL_i
);

  localparam int unsigned DIV_W  = 16;
  localparam int unsigned WAIT_W = 32;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WBIT  = 3'd2,
    S_WACK  = 3'd3,
    S_RBIT  = 3'd4,
    S_MACK  = 3'd5,
    S_STOP  = 3'd6
  } state_t;

  state_t            st;
  logic [DIV_W-1:0]  div_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        phase;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic              ack_bit;
  logic              stall;
  logic              sda_bit;

  assign state = st;
  assign SDA_o = 1'b0;
  assign SCL_o = 1'b0;

  // Phase 2 is where SCL has been released; a slave holding it low freezes the bit.
  assign stall   = (st != S_IDLE) && (phase == 2'd2) && !SCL_i;
  assign sda_bit = (st == S_WBIT) ? shift[7] : ((st == S_WACK) || (st == S_RBIT));

  // Each tick moves to the next phase; pin drives are updated for the phase being entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st       <= S_IDLE;
      div_cnt  <= '0;
      wait_cnt <= '0;
      phase    <= 2'd0;
      bit_cnt  <= 3'd0;
      shift    <= 8'h00;
      ack_bit  <= 1'b0;
      ack      <= 1'b0;
      nack     <= 1'b0;
      ack_r    <= 1'b0;
      timeout  <= 1'b0;
      data_r   <= 8'h00;
      busy     <= 1'b0;
      SDA_t    <= 1'b1;
      SCL_t    <= 1'b1;
    end else begin
      ack     <= 1'b0;
      nack    <= 1'b0;
      ack_r   <= 1'b0;
      timeout <= 1'b0;
      if (st == S_IDLE) begin
        div_cnt  <= '0;
        wait_cnt <= '0;
        phase    <= 2'd0;
        bit_cnt  <= 3'd0;
        if (go) begin
          busy  <= 1'b1;
          shift <= data_w;
          if (stop) begin
            st    <= S_STOP;
            SCL_t <= 1'b0;
          end else if (start) begin
            st    <= S_START;
            SDA_t <= 1'b1;
          end else if (rw) begin
            st    <= S_RBIT;
            SCL_t <= 1'b0;
          end else begin
            st    <= S_WBIT;
            SCL_t <= 1'b0;
          end
        end
      end else if (stall) begin
        div_cnt <= '0;
        if (wait_cnt == WAIT_LAST) begin
          timeout <= 1'b1;
          busy    <= 1'b0;
          st      <= S_IDLE;
          SDA_t   <= 1'b1;
          SCL_t   <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 32'd1;
        end
      end else if (div_cnt != DIV_LAST) begin
        div_cnt <= div_cnt + 16'd1;
      end else begin
        div_cnt  <= '0;
        wait_cnt <= '0;
        case (phase)
          2'd0: begin
            phase <= 2'd1;
            if (st == S_START) SCL_t <= 1'b1;
            else               SDA_t <= sda_bit;
          end
          2'd1: begin
            phase <= 2'd2;
            if (st == S_START) SDA_t <= 1'b0;
            else               SCL_t <= 1'b1;
          end
          2'd2: begin
            phase <= 2'd3;
            if (st == S_START)     SCL_t <= 1'b0;
            else if (st == S_STOP) SDA_t <= 1'b1;
            if (st == S_RBIT) shift   <= {shift[6:0], SDA_i};
            if (st == S_WACK) ack_bit <= SDA_i;
          end
          default: begin
            phase <= 2'd0;
            case (st)
              S_START: begin
                st      <= S_WBIT;
                bit_cnt <= 3'd0;
                SCL_t   <= 1'b0;
              end
              S_WBIT: begin
                shift   <= {shift[6:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
                SCL_t   <= 1'b0;
                if (bit_cnt == 3'd7) st <= S_WACK;
              end
              S_RBIT: begin
                bit_cnt <= bit_cnt + 3'd1;
                SCL_t   <= 1'b0;
                if (bit_cnt == 3'd7) st <= S_MACK;
              end
              S_WACK: begin
                st    <= S_IDLE;
                busy  <= 1'b0;
                SCL_t <= 1'b0;
                if (ack_bit) nack <= 1'b1;
                else         ack  <= 1'b1;
              end
              S_MACK: begin
                st     <= S_IDLE;
                busy   <= 1'b0;
                SCL_t  <= 1'b0;
                ack_r  <= 1'b1;
                data_r <= shift;
              end
              default: begin
                st   <= S_IDLE;
                busy <= 1'b0;
              end
            endcase
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_byte_master.sv
// Directed bench for i2c_byte_master with a small behavioural I2C slave on the bus.
`timescale 1ns/1ps
module tb_i2c_byte_master;

  localparam int unsigned CLK_DIV     = 4;
  localparam int unsigned TIMEOUT_CYC = 200;
  localparam int SL_NONE = 0;
  localparam int SL_ACK  = 1;
  localparam int SL_READ = 2;

  logic       clock  = 1'b0;
  logic       reset  = 1'b1;
  logic       go     = 1'b0;
  logic       start  = 1'b0;
  logic       stop   = 1'b0;
  logic       rw     = 1'b0;
  logic [7:0] data_w = 8'h00;
  logic       ack, nack, ack_r, timeout, busy;
  logic [7:0] data_r;
  logic [2:0] state;
  logic       SDA_t, SCL_t, SDA_o, SCL_o, SDA_i, SCL_i;

  logic       slv_sda;
  logic       slv_arm  = 1'b0;
  logic       scl_hold = 1'b0;
  int         slv_mode = SL_NONE;
  logic [7:0] slv_rd   = 8'h00;
  logic       scl_q, sda_q, ninth, stop_seen;
  logic [7:0] cap;
  int         rises;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       start;
    logic       rw;
    logic [7:0] data_w;
    int         mode;
    logic [7:0] rd_byte;
    logic [3:0] exp_strb;   // {ack, nack, ack_r, timeout}
    logic [7:0] exp_data_r;
    logic [7:0] exp_cap;
    logic       exp_ninth;
    int         exp_cycles;
  } vec_t;

  vec_t vecs [6];

  i2c_byte_master #(.CLK_DIV(CLK_DIV), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clock(clock), .reset(reset), .go(go), .start(start), .stop(stop), .rw(rw),
    .data_w(data_w), .ack(ack), .nack(nack), .ack_r(ack_r), .timeout(timeout),
    .data_r(data_r), .busy(busy), .state(state), .SDA_t(SDA_t), .SCL_t(SCL_t),
    .SDA_o(SDA_o), .SCL_o(SCL_o), .SDA_i(SDA_i), .SCL_i(SCL_i)
  );

  always #5 clock = ~clock;

  // Wired-AND open-drain lines.
  assign SDA_i = (SDA_t ? 1'b1 : SDA_o) & slv_sda;
  assign SCL_i = (SCL_t ? 1'b1 : SCL_o) & ~scl_hold;

  // Slave: counts SCL rises, captures SDA, acks or serves a read byte on SCL falls.
  always @(posedge clock) begin
    if (reset) begin
      slv_sda   <= 1'b1;
      rises     <= 0;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      cap       <= 8'h00;
      ninth     <= 1'b1;
      stop_seen <= 1'b0;
    end else begin
      scl_q <= SCL_i;
      sda_q <= SDA_i;
      if (slv_arm) begin
        rises     <= 0;
        stop_seen <= 1'b0;
        slv_sda   <= (slv_mode == SL_READ) ? slv_rd[7] : 1'b1;
      end else if (scl_q && SCL_i && sda_q && !SDA_i) begin
        rises <= 0;
      end else if (scl_q && SCL_i && !sda_q && SDA_i) begin
        stop_seen <= 1'b1;
      end else if (!scl_q && SCL_i) begin
        if (rises < 8) cap <= {cap[6:0], SDA_i};
        if (rises == 8) ninth <= SDA_i;
        rises <= rises + 1;
      end else if (scl_q && !SCL_i) begin
        if (slv_mode == SL_ACK && rises == 8)      slv_sda <= 1'b0;
        else if (slv_mode == SL_READ && rises < 8) slv_sda <= slv_rd[3'(7 - rises)];
        else                                       slv_sda <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    int         cyc;
    logic [3:0] strb;
    logic       done;
    @(negedge clock);
    start    = vecs[i].start;
    rw       = vecs[i].rw;
    data_w   = vecs[i].data_w;
    slv_mode = vecs[i].mode;
    slv_rd   = vecs[i].rd_byte;
    go       = 1'b1;
    slv_arm  = 1'b1;
    @(negedge clock);
    go = 1'b0; start = 1'b0; rw = 1'b0; slv_arm = 1'b0;
    cyc = 0; strb = 4'b0000; done = 1'b0;
    for (int k = 0; k < 2000 && !done; k++) begin
      strb = {ack, nack, ack_r, timeout};
      if (strb != 4'b0000) done = 1'b1;
      else begin
        if (busy) cyc++;
        @(negedge clock);
      end
    end
    chk($sformatf("v%0d_done", i), 32'(done), 32'(1'b1));
    chk($sformatf("v%0d_strobe", i), 32'(strb), 32'(vecs[i].exp_strb));
    chk($sformatf("v%0d_busy_cycles", i), 32'(cyc), 32'(vecs[i].exp_cycles));
    chk($sformatf("v%0d_busy_at_strobe", i), 32'(busy), 32'(1'b0));
    chk($sformatf("v%0d_data_r", i), 32'(data_r), 32'(vecs[i].exp_data_r));
    chk($sformatf("v%0d_bus_byte", i), 32'(cap), 32'(vecs[i].exp_cap));
    chk($sformatf("v%0d_ninth_sda", i), 32'(ninth), 32'(vecs[i].exp_ninth));
    @(negedge clock);
    chk($sformatf("v%0d_strobe_clear", i), 32'({ack, nack, ack_r, timeout}), 32'(4'b0000));
    chk($sformatf("v%0d_idle_state", i), 32'(state), 32'(3'd0));
    chk($sformatf("v%0d_idle_scl_low", i), 32'(SCL_t), 32'(1'b0));
  endtask

  initial begin
    int cyc, strb_cnt, waits, to_waits, to_cnt, other_cnt;
    logic fin, to_seen;

    //          start rw    data   mode     rd     strb     data_r cap    ninth cyc
    vecs[0] = '{1'b1, 1'b0, 8'hA0, SL_ACK,  8'h00, 4'b1000, 8'h00, 8'hA0, 1'b0, 160};
    vecs[1] = '{1'b0, 1'b0, 8'h55, SL_NONE, 8'h00, 4'b0100, 8'h00, 8'h55, 1'b1, 144};
    vecs[2] = '{1'b0, 1'b1, 8'h00, SL_READ, 8'hC3, 4'b0010, 8'hC3, 8'hC3, 1'b0, 144};
    vecs[3] = '{1'b1, 1'b1, 8'h3C, SL_ACK,  8'h00, 4'b1000, 8'hC3, 8'h3C, 1'b0, 160};
    vecs[4] = '{1'b0, 1'b1, 8'h00, SL_READ, 8'h5A, 4'b0010, 8'h5A, 8'h5A, 1'b0, 144};
    vecs[5] = '{1'b0, 1'b0, 8'hFF, SL_ACK,  8'h00, 4'b1000, 8'h5A, 8'hFF, 1'b0, 144};

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_state", 32'(state), 32'(3'd0));
    chk("rst_busy", 32'(busy), 32'(1'b0));
    chk("rst_strobes", 32'({ack, nack, ack_r, timeout}), 32'(4'b0000));
    chk("rst_data_r", 32'(data_r), 32'(8'h00));
    chk("rst_sda_t", 32'(SDA_t), 32'(1'b1));
    chk("rst_scl_t", 32'(SCL_t), 32'(1'b1));
    chk("rst_pin_out", 32'({SDA_o, SCL_o}), 32'(2'b00));

    for (int i = 0; i < 6; i++) run_vec(i);

    // STOP after a byte, with a second go while busy that must be ignored.
    @(negedge clock);
    stop = 1'b1; go = 1'b1; slv_mode = SL_NONE; slv_arm = 1'b1;
    @(negedge clock);
    stop = 1'b0; slv_arm = 1'b0; go = 1'b1; start = 1'b1; data_w = 8'hEE;
    cyc = 0; strb_cnt = 0; fin = 1'b0;
    for (int k = 0; k < 200 && !fin; k++) begin
      if (ack | nack | ack_r | timeout) strb_cnt++;
      if (busy) cyc++;
      else fin = 1'b1;
      if (!fin) @(negedge clock);
      go = 1'b0; start = 1'b0;
    end
    chk("stop_done", 32'(fin), 32'(1'b1));
    chk("stop_busy_cycles", 32'(cyc), 32'(16));
    chk("stop_no_strobe", 32'(strb_cnt), 32'(0));
    chk("stop_condition_seen", 32'(stop_seen), 32'(1'b1));
    chk("stop_sda_released", 32'(SDA_t), 32'(1'b1));
    chk("stop_scl_released", 32'(SCL_t), 32'(1'b1));
    repeat (3) @(negedge clock);
    chk("stop_go_ignored_state", 32'(state), 32'(3'd0));
    chk("stop_go_ignored_busy", 32'(busy), 32'(1'b0));

    // Slave stretches SCL for 300 clocks during a write.
    rw = 1'b0; data_w = 8'h81; slv_mode = SL_ACK; go = 1'b1; slv_arm = 1'b1;
    @(negedge clock);
    go = 1'b0; slv_arm = 1'b0;
    repeat (20) @(negedge clock);
    for (int k = 0; k < 100 && SCL_t; k++) @(negedge clock);
    chk("to_scl_low_before_hold", 32'(SCL_t), 32'(1'b0));
    scl_hold = 1'b1;
    waits = 0; to_waits = 0; to_cnt = 0; other_cnt = 0; to_seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (busy && SCL_t && !SCL_i) waits++;
      if (ack | nack | ack_r) other_cnt++;
      if (timeout) begin
        to_cnt++;
        if (!to_seen) begin
          to_seen  = 1'b1;
          to_waits = waits;
          chk("to_sda_released", 32'(SDA_t), 32'(1'b1));
          chk("to_scl_released", 32'(SCL_t), 32'(1'b1));
          chk("to_busy", 32'(busy), 32'(1'b0));
          chk("to_state", 32'(state), 32'(3'd0));
        end
      end
      @(negedge clock);
    end
    scl_hold = 1'b0;
    chk("to_pulse_count", 32'(to_cnt), 32'(1));
    chk("to_wait_clocks", 32'(to_waits), 32'(200));
    chk("to_no_other_strobe", 32'(other_cnt), 32'(0));

    // Reset in the middle of bit 4 of a write.
    repeat (4) @(negedge clock);
    rw = 1'b0; data_w = 8'hF0; slv_mode = SL_ACK; go = 1'b1; slv_arm = 1'b1;
    @(negedge clock);
    go = 1'b0; slv_arm = 1'b0;
    repeat (70) @(negedge clock);
    chk("rst_mid_busy_before", 32'(busy), 32'(1'b1));
    chk("rst_mid_sda_driven_before", 32'(SDA_t), 32'(1'b0));
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_mid_sda_t", 32'(SDA_t), 32'(1'b1));
    chk("rst_mid_scl_t", 32'(SCL_t), 32'(1'b1));
    chk("rst_mid_busy", 32'(busy), 32'(1'b0));
    chk("rst_mid_state", 32'(state), 32'(3'd0));
    chk("rst_mid_data_r", 32'(data_r), 32'(8'h00));
    chk("rst_mid_strobes", 32'({ack, nack, ack_r, timeout}), 32'(4'b0000));
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
